// File: rtl/ldpc_dec_sequencer_if.sv
// Handshake and status bundle between the LDPC run sequencer and its
// configuration registers / encoder-decoder datapath.
interface ldpc_dec_sequencer_if #(
  parameter int unsigned SUM_LEN = 32,
  parameter int unsigned TMO_W   = 16
);
  logic               cfg_start;
  logic               cfg_abort;
  logic               cfg_err_intro;
  logic [SUM_LEN-1:0] cfg_loop_max;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               irq_clr;
  logic               enc_start;
  logic               enc_valid;
  logic               err_load;
  logic               dec_start;
  logic               dec_iter_done;
  logic               dec_syn_ok;
  logic               busy;
  logic               done;
  logic               pass;
  logic               timeout_err;
  logic [SUM_LEN-1:0] iter_count;
  logic               irq;

  modport master (
    input  cfg_start, cfg_abort, cfg_err_intro, cfg_loop_max, cfg_timeout, irq_clr,
    input  enc_valid, dec_iter_done, dec_syn_ok,
    output enc_start, err_load, dec_start, busy, done, pass, timeout_err, iter_count, irq
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_err_intro, cfg_loop_max, cfg_timeout, irq_clr,
    output enc_valid, dec_iter_done, dec_syn_ok,
    input  enc_start, err_load, dec_start, busy, done, pass, timeout_err, iter_count, irq
  );
endinterface

// File: rtl/ldpc_dec_sequencer.sv
// Run-level controller: encoder launch, optional error load, bounded decoder
// iterations with a per-handshake watchdog; reports pass/fail and a sticky irq.
module ldpc_dec_sequencer #(
  parameter int unsigned SUM_LEN = 32,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  ldpc_dec_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ENC,
    ERR,
    DEC_LAUNCH,
    DEC_WAIT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               err_intro_q;
  logic [SUM_LEN-1:0] loop_max_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   wd_cnt;
  logic [TMO_W:0]     wd_inc;
  logic               wd_trip;
  logic               abort;
  logic               start_run;
  logic               set_pass;
  logic               set_tmo;

  assign abort   = bus.cfg_abort && (state != IDLE);
  assign wd_inc  = {1'b0, wd_cnt} + {{TMO_W{1'b0}}, 1'b1};
  // Trips in the wait cycle that brings the count up to the limit
  assign wd_trip = (tmo_q != '0) && (wd_inc >= {1'b0, tmo_q});

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    set_pass  = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          state_nxt = ENC;
          start_run = 1'b1;
        end
      end
      ENC: begin
        if (bus.enc_valid) begin
          state_nxt = err_intro_q ? ERR : DEC_LAUNCH;
        end else if (wd_trip) begin
          state_nxt = DONE;
          set_tmo   = 1'b1;
        end
      end
      ERR:        state_nxt = DEC_LAUNCH;
      DEC_LAUNCH: state_nxt = DEC_WAIT;
      DEC_WAIT: begin
        if (bus.dec_iter_done) begin
          if (bus.dec_syn_ok) begin
            state_nxt = DONE;
            set_pass  = 1'b1;
          end else if (bus.iter_count >= loop_max_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DEC_LAUNCH;
          end
        end else if (wd_trip) begin
          state_nxt = DONE;
          set_tmo   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      set_pass  = 1'b0;
      set_tmo   = 1'b0;
    end
  end

  // Strobes are registered from the next state so they line up with the state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      err_intro_q     <= 1'b0;
      loop_max_q      <= '0;
      tmo_q           <= '0;
      wd_cnt          <= '0;
      bus.enc_start   <= 1'b0;
      bus.err_load    <= 1'b0;
      bus.dec_start   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.iter_count  <= '0;
      bus.irq         <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.enc_start <= (state == IDLE) && (state_nxt == ENC);
      bus.err_load  <= (state_nxt == ERR);
      bus.dec_start <= (state_nxt == DEC_LAUNCH);
      bus.done      <= (state_nxt == DONE);
      bus.busy      <= (state_nxt != IDLE);

      if (start_run) begin
        err_intro_q     <= bus.cfg_err_intro;
        loop_max_q      <= (bus.cfg_loop_max == '0) ? SUM_LEN'(1) : bus.cfg_loop_max;
        tmo_q           <= bus.cfg_timeout;
        bus.pass        <= 1'b0;
        bus.timeout_err <= 1'b0;
        bus.iter_count  <= '0;
      end else begin
        if (set_pass) bus.pass <= 1'b1;
        if (set_tmo)  bus.timeout_err <= 1'b1;
        if ((state_nxt == DEC_LAUNCH) && (bus.iter_count != '1)) begin
          bus.iter_count <= bus.iter_count + SUM_LEN'(1);
        end
      end

      if (state_nxt != state) begin
        wd_cnt <= '0;
      end else if ((state == ENC) || (state == DEC_WAIT)) begin
        wd_cnt <= wd_cnt + TMO_W'(1);
      end

      if ((state == DONE) && !abort) begin
        bus.irq <= 1'b1;
      end else if (bus.irq_clr) begin
        bus.irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_dec_sequencer.sv
// Self-checking bench for ldpc_dec_sequencer: a reactive datapath responder
// plus a timeline model of each run derived from the run parameters.
module tb_ldpc_dec_sequencer;
  localparam int unsigned SUM_LEN = 32;
  localparam int unsigned TMO_W   = 16;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b0;
  int checks   = 0;
  int failures = 0;

  ldpc_dec_sequencer_if #(.SUM_LEN(SUM_LEN), .TMO_W(TMO_W)) bus ();

  ldpc_dec_sequencer #(.SUM_LEN(SUM_LEN), .TMO_W(TMO_W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic clear_inputs();
    bus.cfg_start     = 1'b0;
    bus.cfg_abort     = 1'b0;
    bus.cfg_err_intro = 1'b0;
    bus.cfg_loop_max  = '0;
    bus.cfg_timeout   = '0;
    bus.irq_clr       = 1'b0;
    bus.enc_valid     = 1'b0;
    bus.dec_iter_done = 1'b0;
    bus.dec_syn_ok    = 1'b0;
  endtask

  // Timeline of one run. Cycle 0 holds cfg_start; ENC begins in cycle 1.
  // d: enc_valid d cycles after enc_start (<0 never); r: dec_iter_done r cycles
  // after the first wait cycle; c: iteration that converges (0 never).
  function automatic void model(input int d, input int e, input int lmax, input int c,
                                input int r, input int tmo, output int done_t,
                                output int iters, output bit pass, output bit terr,
                                output int errs);
    int leff, t_dec, ws, di;
    leff = (lmax == 0) ? 1 : lmax;
    iters = 0; pass = 1'b0; terr = 1'b0; done_t = -1; errs = 0;
    if (tmo != 0 && (d < 0 || d + 1 > tmo)) begin
      done_t = tmo + 1;
      terr   = 1'b1;
      return;
    end
    errs  = e;
    t_dec = d + 2 + e;
    for (int k = 1; k <= 64; k++) begin
      iters = k;
      ws    = t_dec + 1;
      if (tmo != 0 && r + 1 > tmo) begin
        done_t = ws + tmo;
        terr   = 1'b1;
        return;
      end
      di = ws + r;
      if (k == c) begin
        pass   = 1'b1;
        done_t = di + 1;
        return;
      end
      if (k >= leff) begin
        done_t = di + 1;
        return;
      end
      t_dec = di + 1;
    end
  endfunction

  task automatic run_scn(input string name, input int d, input int e, input int lmax,
                         input int c, input int r, input int tmo, input bit poke);
    int x_done, x_iters, x_errs;
    bit x_pass, x_terr;
    int enc_at, dd_at, n_enc, n_dec, n_err, n_done, t_done, busy_bad;
    bit g_pass, g_terr;
    logic [SUM_LEN-1:0] g_iter;
    model(d, e, lmax, c, r, tmo, x_done, x_iters, x_pass, x_terr, x_errs);
    enc_at = -1; dd_at = -1; n_enc = 0; n_dec = 0; n_err = 0; n_done = 0;
    t_done = -1; busy_bad = 0; g_pass = 1'b0; g_terr = 1'b0; g_iter = '0;
    @(negedge wb_clk_i);
    clear_inputs();
    bus.cfg_err_intro = e[0];
    bus.cfg_loop_max  = SUM_LEN'(lmax);
    bus.cfg_timeout   = TMO_W'(tmo);
    bus.cfg_start     = 1'b1;
    for (int t = 1; t <= 400; t++) begin
      @(negedge wb_clk_i);
      clear_inputs();
      bus.cfg_start     = poke && (t == 2);
      bus.cfg_err_intro = ~e[0];
      bus.cfg_loop_max  = SUM_LEN'($urandom_range(0, 3));
      bus.cfg_timeout   = TMO_W'($urandom_range(1, 3));
      bus.dec_syn_ok    = 1'($urandom);
      if (t_done >= 0 && t == t_done + 1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          failures++; $display("FAIL %s_busy_after_done: got %b want 0", name, bus.busy);
        end
        checks++;
        if (bus.irq !== 1'b1) begin
          failures++; $display("FAIL %s_irq_vs_clr: got %b want 1", name, bus.irq);
        end
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.enc_start === 1'b1) begin
        n_enc++;
        if (d >= 0) enc_at = t + d;
      end
      if (bus.err_load === 1'b1) n_err++;
      if (bus.dec_start === 1'b1) begin
        n_dec++;
        dd_at = t + 1 + r;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (t_done < 0) begin
          t_done = t;
          g_pass = bus.pass;
          g_terr = bus.timeout_err;
          g_iter = bus.iter_count;
        end
        bus.irq_clr = 1'b1;
      end
      if (t == enc_at) bus.enc_valid = 1'b1;
      if (t == dd_at) begin
        bus.dec_iter_done = 1'b1;
        bus.dec_syn_ok    = (n_dec == c);
      end
    end
    checks++;
    if (t_done !== x_done) begin
      failures++; $display("FAIL %s_done_cycle: got %0d want %0d", name, t_done, x_done);
    end
    checks++;
    if (n_done !== 1) begin
      failures++; $display("FAIL %s_done_count: got %0d want 1", name, n_done);
    end
    checks++;
    if (g_pass !== x_pass) begin
      failures++; $display("FAIL %s_pass: got %b want %b", name, g_pass, x_pass);
    end
    checks++;
    if (g_terr !== x_terr) begin
      failures++; $display("FAIL %s_timeout_err: got %b want %b", name, g_terr, x_terr);
    end
    checks++;
    if (g_iter !== SUM_LEN'(x_iters)) begin
      failures++; $display("FAIL %s_iter_count: got %0d want %0d", name, g_iter, x_iters);
    end
    checks++;
    if (n_dec !== x_iters) begin
      failures++; $display("FAIL %s_dec_starts: got %0d want %0d", name, n_dec, x_iters);
    end
    checks++;
    if (n_err !== x_errs) begin
      failures++; $display("FAIL %s_err_loads: got %0d want %0d", name, n_err, x_errs);
    end
    checks++;
    if (n_enc !== 1 || busy_bad !== 0) begin
      failures++; $display("FAIL %s_enc_busy: got enc=%0d busy_drops=%0d want 1/0", name, n_enc, busy_bad);
    end
    clear_inputs();
    bus.irq_clr = 1'b1;
    @(negedge wb_clk_i);
    clear_inputs();
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL %s_irq_clr: got %b want 0", name, bus.irq);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if ({bus.enc_start, bus.err_load, bus.dec_start, bus.busy, bus.done, bus.pass,
         bus.timeout_err, bus.irq} !== 8'h00 || bus.iter_count !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero outputs want all 0");
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (bus.busy !== 1'b0 || bus.enc_start !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got busy=%b enc_start=%b want 0/0", bus.busy, bus.enc_start);
    end
  endtask

  task automatic test_wdog_off();
    int n_done, n_dec, n_enc;
    n_done = 0; n_dec = 0; n_enc = 0;
    @(negedge wb_clk_i);
    clear_inputs();
    bus.cfg_loop_max = SUM_LEN'(3);
    bus.cfg_start    = 1'b1;
    for (int t = 1; t <= 1000; t++) begin
      @(negedge wb_clk_i);
      clear_inputs();
      if (bus.done === 1'b1) n_done++;
      if (bus.dec_start === 1'b1) n_dec++;
      if (bus.enc_start === 1'b1) n_enc++;
    end
    checks++;
    if (bus.busy !== 1'b1 || n_done !== 0 || n_dec !== 0 || n_enc !== 1) begin
      failures++;
      $display("FAIL wdog_off_stall: got busy=%b done=%0d dec=%0d enc=%0d want 1/0/0/1",
               bus.busy, n_done, n_dec, n_enc);
    end
    bus.cfg_abort = 1'b1;
    @(negedge wb_clk_i);
    clear_inputs();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL wdog_off_abort: got busy=%b done=%b terr=%b want 0/0/0",
               bus.busy, bus.done, bus.timeout_err);
    end
    @(negedge wb_clk_i);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL wdog_off_abort_irq: got %b want 0", bus.irq);
    end
  endtask

  task automatic test_abort();
    int n_done, t_ds;
    bit hit;
    n_done = 0; t_ds = -1; hit = 1'b0;
    @(negedge wb_clk_i);
    clear_inputs();
    bus.cfg_loop_max = SUM_LEN'(4);
    bus.cfg_start    = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge wb_clk_i);
      clear_inputs();
      if (bus.done === 1'b1) n_done++;
      if (hit) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.pass !== 1'b0 || bus.iter_count !== SUM_LEN'(1)) begin
          failures++;
          $display("FAIL abort_result: got busy=%b pass=%b iter=%0d want 0/0/1",
                   bus.busy, bus.pass, bus.iter_count);
        end
        hit = 1'b0;
      end
      if (bus.enc_start === 1'b1) bus.enc_valid = 1'b1;
      if (bus.dec_start === 1'b1) t_ds = t;
      if (t_ds >= 0 && t == t_ds + 1) begin
        bus.dec_iter_done = 1'b1;
        bus.dec_syn_ok    = 1'b1;
        bus.cfg_abort     = 1'b1;
        hit = 1'b1;
      end
    end
    checks++;
    if (n_done !== 0 || bus.irq !== 1'b0 || t_ds < 0) begin
      failures++;
      $display("FAIL abort_no_done: got done=%0d irq=%b launched=%0d want 0/0/>=0", n_done, bus.irq, t_ds);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    seen = -1;
    @(negedge wb_clk_i);
    clear_inputs();
    bus.cfg_loop_max = SUM_LEN'(2);
    bus.cfg_start    = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(negedge wb_clk_i);
      clear_inputs();
      if (bus.enc_start === 1'b1) bus.enc_valid = 1'b1;
      if (bus.dec_start === 1'b1) seen = t;
      if (seen >= 0 && t == seen + 2) break;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.iter_count !== SUM_LEN'(1)) begin
      failures++; $display("FAIL arst_precond: got busy=%b iter=%0d want 1/1", bus.busy, bus.iter_count);
    end
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if ({bus.enc_start, bus.err_load, bus.dec_start, bus.busy, bus.done, bus.pass,
         bus.timeout_err, bus.irq} !== 8'h00 || bus.iter_count !== '0) begin
      failures++; $display("FAIL arst_outputs: got busy=%b iter=%0d want 0/0", bus.busy, bus.iter_count);
    end
    #1 wb_rst_i = 1'b0;
    run_scn("after_arst", 1, 0, 3, 2, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int d, e, lmax, c, r, tmo;
    for (int n = 0; n < 25; n++) begin
      d    = $urandom_range(0, 4);
      e    = $urandom_range(0, 1);
      lmax = $urandom_range(0, 6);
      c    = $urandom_range(0, 7);
      r    = $urandom_range(0, 3);
      tmo  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_scn($sformatf("rand%0d", n), d, e, lmax, c, r, tmo, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    run_scn("clean", 3, 0, 10, 1, 1, 0, 1'b0);
    run_scn("iter_limit", 2, 1, 5, 0, 2, 0, 1'b0);
    run_scn("converge3", 1, 0, 8, 3, 0, 0, 1'b0);
    run_scn("loop_max0", 0, 0, 0, 0, 0, 0, 1'b0);
    run_scn("min_run", 0, 0, 1, 1, 0, 0, 1'b0);
    run_scn("start_busy", 4, 1, 3, 2, 1, 0, 1'b1);
    run_scn("wdog_enc", -1, 0, 4, 0, 0, 20, 1'b0);
    run_scn("wdog_dec", 1, 1, 4, 0, 30, 12, 1'b0);
    run_scn("wdog_tie", 4, 0, 2, 1, 4, 5, 1'b0);
    test_wdog_off();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ldpc_dec_sequencer.md
# ldpc_dec_sequencer

Run-level controller for the LDPC encode/decode datapath. On one start command it sequences the encoder, the optional error-injection load and the iterative decoder, and bounds the decoder by an iteration limit and a watchdog. It reports pass/fail, the iteration count and a sticky interrupt. It sits between the Wishbone/LA configuration registers and the `ldpcEncDec` datapath handshakes.

## Interface

Parameters:
- `SUM_LEN`, 32, width of the iteration limit and the iteration counter
- `TMO_W`, 16, width of the watchdog limit and the watchdog counter

Ports:
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `cfg_start`  in  1  start-run pulse; sampled only in IDLE
- `cfg_abort`  in  1  abort current run; level, checked every cycle
- `cfg_err_intro`  in  1  include the ERR stage; sampled at start
- `cfg_loop_max`  in  SUM_LEN  maximum decoder iterations; sampled at start; 0 is treated as 1
- `cfg_timeout`  in  TMO_W  maximum wait cycles per handshake; sampled at start; 0 disables the watchdog
- `irq_clr`  in  1  clears `irq`
- `enc_start`  out  1  one-cycle encoder launch
- `enc_valid`  in  1  encoder codeword valid
- `err_load`  out  1  one-cycle error-pattern load strobe
- `dec_start`  out  1  one-cycle launch of one decoder iteration
- `dec_iter_done`  in  1  one-cycle end-of-iteration pulse
- `dec_syn_ok`  in  1  syndrome equals the expected syndrome; valid only with `dec_iter_done`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle end-of-run pulse
- `pass`  out  1  result of the last run; held until the next start
- `timeout_err`  out  1  last run ended by the watchdog
- `iter_count`  out  SUM_LEN  iterations launched in the current or last run
- `irq`  out  1  sticky; set with `done`

## Operation

- States: IDLE, ENC, ERR, DEC_LAUNCH, DEC_WAIT, DONE. All outputs are registered.
- IDLE:
  - `cfg_start=1` latches the cfg inputs.
  - Clears `pass`, `timeout_err`, `iter_count` and the watchdog counter.
  - Moves to ENC.
- ENC:
  - `enc_start=1` in the first ENC cycle only.
  - The state waits for `enc_valid`. If `enc_valid` is already high in the `enc_start` cycle, it is accepted.
  - On `enc_valid`, go to ERR if the latched err_intro is 1, else to DEC_LAUNCH.
- ERR: `err_load=1` for exactly one cycle, then DEC_LAUNCH.
- DEC_LAUNCH: `dec_start=1` for one cycle, `iter_count` increments by 1, then DEC_WAIT.
- DEC_WAIT, on `dec_iter_done`:
  - `dec_syn_ok=1`: go to DONE with `pass=1`.
  - Else if `iter_count >= loop_max_eff`: go to DONE with `pass=0`.
  - Else: go to DEC_LAUNCH.
- DONE: `done=1` and `irq<=1` for one cycle, then IDLE.
- Watchdog:
  - The counter increments each cycle in ENC and DEC_WAIT and clears on every state change.
  - When it reaches the latched timeout (nonzero), go to DONE with `pass=0` and `timeout_err=1`.
- Abort: `cfg_abort=1` in any non-IDLE state forces IDLE next cycle.
  - No `done`, no `irq`.
  - `pass`, `timeout_err` and `iter_count` keep their current values.
- Priority within one cycle:
  - Abort wins over `dec_iter_done`, `enc_valid` and the watchdog.
  - A valid handshake wins over the watchdog in the same cycle.
  - `irq` set wins over `irq_clr`.
- Ignored inputs:
  - `cfg_start` outside IDLE.
  - `dec_iter_done` outside DEC_WAIT.
  - `enc_valid` outside ENC.
- Arithmetic: `iter_count` saturates at all-ones and never wraps.

## Timing

- Reset values: state IDLE; every output 0 (`enc_start`, `err_load`, `dec_start`, `busy`, `done`, `pass`, `timeout_err`, `iter_count`, `irq`).
- `cfg_start` sampled at edge N gives `busy=1` and `enc_start=1` in cycle N+1.
- From `enc_valid` at edge M:
  - With ERR: `err_load` in cycle M+1, `dec_start` in M+2.
  - Without ERR: `dec_start` in M+1.
- From `dec_iter_done` at edge K:
  - Next `dec_start` in K+1 (2-cycle minimum gap between `dec_start` pulses).
  - Or `done` in K+1, with `pass` already valid in K+1.
- `busy` falls in the cycle after `done`. The next start is accepted one cycle after `done`.
- Minimum run with no ERR, 1 iteration and zero-latency responses: `done` 4 cycles after start.
- Asserting `wb_rst_i` mid-run returns all outputs to reset values immediately, independent of the clock.

## Test plan

- Clean run: start, err_intro=0, loop_max=10; `enc_valid` 3 cycles after `enc_start`; `dec_syn_ok=1` on the 1st `dec_iter_done` -> `pass=1`, `iter_count=1`, one `done`, `irq=1`, no `err_load`.
- Iteration limit: err_intro=1, loop_max=5, `dec_syn_ok` never high -> exactly one `err_load`, exactly 5 `dec_start` pulses, `pass=0`, `iter_count=5`, `timeout_err=0`.
- Convergence on iteration 3 of loop_max=8 -> 3 `dec_start` pulses, `pass=1`, `iter_count=3`. Repeat with loop_max=0 -> 1 iteration.
- Watchdog: timeout=20, `enc_valid` withheld -> `done` 20 cycles after the first ENC cycle, `timeout_err=1`, no `dec_start`. Repeat with timeout=0 -> stays in ENC for 1000 cycles.
- Abort and simultaneous events:
  - `cfg_abort` coincident with `dec_iter_done` and `dec_syn_ok=1` -> IDLE, no `done`, `pass=0`.
  - `cfg_start` while busy -> ignored.
  - `irq_clr` coincident with `done` -> `irq=1`.
- Async reset mid-DEC_WAIT -> all outputs 0 without a clock edge. A subsequent start runs normally.
